// File: rtl/bnn_conv_kxk_mc_if.sv
// Streaming bus of the binary KxK convolution engine: weight beats in, window columns in, channel sums out.
interface bnn_conv_kxk_mc_if #(
  parameter int K      = 3,
  parameter int CH_OUT = 4
);
  localparam int SW = $clog2(K*K+1) + 1;

  logic                 wt_valid;
  logic [CH_OUT-1:0]    wt_bits;
  logic                 wt_ready;
  logic                 in_valid;
  logic [K-1:0]         taps;
  logic [CH_OUT*SW-1:0] dout;
  logic                 ovalid;

  modport master (
    output wt_valid, wt_bits, in_valid, taps,
    input  wt_ready, dout, ovalid
  );

  modport slave (
    input  wt_valid, wt_bits, in_valid, taps,
    output wt_ready, dout, ovalid
  );
endinterface

// File: rtl/bnn_conv_kxk_mc.sv
// Binary XNOR/popcount KxK convolution with CH_OUT parallel channels and an IDLE/RUN/DRAIN controller.
// Optional sign activation against a per-channel threshold: define BNN_CONV_SIGN_ACT_EN.
module bnn_conv_kxk_mc #(
  parameter  int K      = 3,
  parameter  int CH_OUT = 4,
  parameter  int CFG_W  = 8,
  localparam int SW     = $clog2(K*K+1) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CFG_W-1:0]     cfg_cols,
  input  logic [CFG_W-1:0]     cfg_rows,
`ifdef BNN_CONV_SIGN_ACT_EN
  input  logic [CH_OUT*SW-1:0] thr,
`endif
  output logic                 done,
  output logic                 busy,
  bnn_conv_kxk_mc_if.slave     bus
);

  localparam int NW = K*K;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NW-1);
  localparam logic [CFG_W-1:0] COL_MIN  = CFG_W'(K-1);
`ifdef BNN_CONV_SIGN_ACT_EN
  localparam logic [2:0]       DRAIN_LAST = 3'd3;
`else
  localparam logic [2:0]       DRAIN_LAST = 3'd2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [IW-1:0]    wt_idx;
  logic             wt_loaded;
  logic [NW-1:0]    w [CH_OUT];
  logic [CFG_W-1:0] cols_q;
  logic [CFG_W-1:0] rows_q;
  logic [CFG_W-1:0] ccnt;
  logic [CFG_W-1:0] rcnt;
  logic [2:0]       dcnt;
`ifdef BNN_CONV_SIGN_ACT_EN
  logic [CH_OUT*SW-1:0] thr_q;
`endif

  logic          accept;
  logic          win_ok;
  logic [K-1:0]  col_sr [K-1];
  logic [NW-1:0] win_vec;

  assign accept = (state == RUN) && bus.in_valid;
  assign win_ok = accept && (ccnt >= COL_MIN);

  function automatic logic [SW-1:0] popcnt(input logic [NW-1:0] x);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < NW; i++) n = n + SW'(x[i]);
    return n;
  endfunction

  // Map popcount p to the +/-1 dot product 2p - K*K; modular arithmetic is exact since the result fits SW bits.
  function automatic logic [SW-1:0] to_sum(input logic [SW-1:0] pop);
    return SW'({pop, 1'b0}) - SW'(NW);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      bus.wt_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wt_idx       <= '0;
      wt_loaded    <= 1'b0;
      cols_q       <= '0;
      rows_q       <= '0;
      ccnt         <= '0;
      rcnt         <= '0;
      dcnt         <= '0;
      for (int c = 0; c < CH_OUT; c++) w[c] <= '0;
`ifdef BNN_CONV_SIGN_ACT_EN
      thr_q        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wt_valid && bus.wt_ready) begin
            for (int c = 0; c < CH_OUT; c++) w[c][wt_idx] <= bus.wt_bits[c];
            if (wt_idx == IDX_LAST) begin
              wt_idx    <= '0;
              wt_loaded <= 1'b1;
            end else begin
              wt_idx <= wt_idx + 1'b1;
            end
          end
          if (start && wt_loaded) begin
            state        <= RUN;
            busy         <= 1'b1;
            bus.wt_ready <= 1'b0;
            cols_q       <= cfg_cols;
            rows_q       <= cfg_rows;
            ccnt         <= '0;
            rcnt         <= '0;
`ifdef BNN_CONV_SIGN_ACT_EN
            thr_q        <= thr;
`endif
          end else begin
            bus.wt_ready <= 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (ccnt == cols_q - 1'b1) begin
              ccnt <= '0;
              if (rcnt == rows_q - 1'b1) begin
                state <= DRAIN;
                dcnt  <= '0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end else begin
              ccnt <= ccnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            bus.wt_ready <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // col_sr[0] is the oldest stored column; the live taps complete the window as column K-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < K-1; i++) col_sr[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < K-2; i++) col_sr[i] <= col_sr[i+1];
      col_sr[K-2] <= bus.taps;
    end
  end

  always_comb begin
    win_vec = '0;
    for (int r = 0; r < K; r++) begin
      for (int col = 0; col < K-1; col++) win_vec[r*K+col] = col_sr[col][K-1-r];
      win_vec[r*K+K-1] = bus.taps[K-1-r];
    end
  end

  logic                s1_v;
  logic                s2_v;
  logic [NW-1:0]       s1_x   [CH_OUT];
  logic [SW-1:0]       s2_pop [CH_OUT];
`ifdef BNN_CONV_SIGN_ACT_EN
  logic                s3_v;
  logic [SW-1:0]       s3_sum [CH_OUT];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      bus.ovalid <= 1'b0;
      bus.dout   <= '0;
      for (int c = 0; c < CH_OUT; c++) begin
        s1_x[c]   <= '0;
        s2_pop[c] <= '0;
      end
`ifdef BNN_CONV_SIGN_ACT_EN
      s3_v <= 1'b0;
      for (int c = 0; c < CH_OUT; c++) s3_sum[c] <= '0;
`endif
    end else begin
      s1_v <= win_ok;
      s2_v <= s1_v;
      for (int c = 0; c < CH_OUT; c++) begin
        s1_x[c]   <= ~(win_vec ^ w[c]);
        s2_pop[c] <= popcnt(s1_x[c]);
      end
`ifdef BNN_CONV_SIGN_ACT_EN
      s3_v       <= s2_v;
      bus.ovalid <= s3_v;
      for (int c = 0; c < CH_OUT; c++) begin
        s3_sum[c] <= to_sum(s2_pop[c]);
        if (s3_v)
          bus.dout[c*SW +: SW] <= {{(SW-1){1'b0}},
                                   $signed(s3_sum[c]) >= $signed(thr_q[c*SW +: SW])};
      end
`else
      bus.ovalid <= s2_v;
      for (int c = 0; c < CH_OUT; c++) begin
        if (s2_v) bus.dout[c*SW +: SW] <= to_sum(s2_pop[c]);
      end
`endif
    end
  end

endmodule

// File: tb/tb_bnn_conv_kxk_mc.sv
// Directed bench for bnn_conv_kxk_mc with K=3, CH_OUT=2; honours BNN_CONV_SIGN_ACT_EN when defined.
module tb_bnn_conv_kxk_mc;
  localparam int K  = 3;
  localparam int CH = 2;
  localparam int SW = 5;
`ifdef BNN_CONV_SIGN_ACT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] cfg_cols;
  logic [7:0] cfg_rows;
  logic       done;
  logic       busy;
  logic [8:0] cur_w0;
  logic [8:0] cur_w1;
  logic [9:0] last_d;
  int         tests = 0;
  int         failures = 0;
`ifdef BNN_CONV_SIGN_ACT_EN
  logic [CH*SW-1:0] thr;
`endif

  bnn_conv_kxk_mc_if #(.K(K), .CH_OUT(CH)) bus ();

  bnn_conv_kxk_mc #(.K(K), .CH_OUT(CH), .CFG_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .cfg_cols (cfg_cols),
    .cfg_rows (cfg_rows),
`ifdef BNN_CONV_SIGN_ACT_EN
    .thr      (thr),
`endif
    .done     (done),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] t);
    bus.in_valid = v;
    bus.taps     = t;
    step();
  endtask

  task automatic loadWeights(input logic [8:0] w0, input logic [8:0] w1, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.wt_valid = 1'b1;
      bus.wt_bits  = {w1[i], w0[i]};
      step();
    end
    bus.wt_valid = 1'b0;
  endtask

  // Signed +/-1 dot product of weights and window; h0 is the oldest column, taps[2-r] is row r.
  function automatic int windowSum(input logic [8:0] w, input logic [2:0] h0, input logic [2:0] h1,
                                   input logic [2:0] h2);
    int s;
    logic x;
    s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int col = 0; col < 3; col++) begin
        x = (col == 0) ? h0[2-r] : (col == 1) ? h1[2-r] : h2[2-r];
        s += (x == w[r*3+col]) ? 1 : -1;
      end
    end
    return s;
  endfunction

  function automatic logic [9:0] expOut(input int s0, input int s1);
    logic [4:0] a;
    logic [4:0] b;
`ifdef BNN_CONV_SIGN_ACT_EN
    a = {4'b0, s0 >= 3};
    b = {4'b0, s1 >= -3};
`else
    a = 5'(s0);
    b = 5'(s1);
`endif
    return {b, a};
  endfunction

  function automatic logic [2:0] tapPattern(input int n);
    return 3'((n * 3 + 1) % 8);
  endfunction

  task automatic runFrame(input string tag, input int cols, input int rows, input int stall_at,
                          input int stall_len, input bit patt, output logic [9:0] last_out);
    logic       exp_v [128];
    logic [9:0] exp_d [128];
    logic [2:0] h0, h1, h2, t;
    logic       v;
    int n_in, ccnt, cyc, got, stall_left, last_in;
    for (int i = 0; i < 128; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end
    h0 = '0; h1 = '0; h2 = '0;
    n_in = 0; ccnt = 0; cyc = 0; got = 0; stall_left = stall_len; last_in = 1000;
    last_out = '0;
    cfg_cols = 8'(cols);
    cfg_rows = 8'(rows);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput({tag, "_busy_start"}, busy, 1);
    while (cyc < 120) begin
      v = 1'b0;
      if (n_in < cols * rows) begin
        if (stall_at == n_in && stall_left > 0) stall_left--;
        else v = 1'b1;
      end
      t = patt ? tapPattern(n_in) : 3'b111;
      applyStimulus(v, t);
      if (v) begin
        h0 = h1; h1 = h2; h2 = t;
        if (ccnt >= K-1) begin
          exp_v[cyc] = 1'b1;
          exp_d[cyc] = expOut(windowSum(cur_w0, h0, h1, h2), windowSum(cur_w1, h0, h1, h2));
        end
        ccnt = (ccnt == cols - 1) ? 0 : ccnt + 1;
        n_in++;
        if (n_in == cols * rows) last_in = cyc;
      end
      cyc++;
      checkOutput({tag, "_ovalid"}, bus.ovalid, (cyc >= LAT) ? exp_v[cyc-LAT] : 1'b0);
      if (cyc >= LAT && exp_v[cyc-LAT]) begin
        checkOutput({tag, "_dout"}, bus.dout, exp_d[cyc-LAT]);
        last_out = exp_d[cyc-LAT];
        got++;
      end
      checkOutput({tag, "_done"}, done, cyc == last_in + LAT + 1);
      checkOutput({tag, "_busy"}, busy, cyc <= last_in + LAT);
      if (cyc == last_in + LAT + 1) break;
    end
    checkOutput({tag, "_end_cycle"}, cyc, last_in + LAT + 1);
    checkOutput({tag, "_out_count"}, got, rows * (cols - K + 1));
  endtask

  initial begin
    rstn         = 1'b0;
    start        = 1'b0;
    cfg_cols     = '0;
    cfg_rows     = '0;
    bus.wt_valid = 1'b0;
    bus.wt_bits  = '0;
    bus.in_valid = 1'b0;
    bus.taps     = '0;
`ifdef BNN_CONV_SIGN_ACT_EN
    thr = {5'b11101, 5'b00011};
`endif
    #12;
    checkOutput("reset_dout", bus.dout, 0);
    checkOutput("reset_ovalid", bus.ovalid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wt_ready", bus.wt_ready, 0);
    rstn = 1'b1;
    step();
    step();
    checkOutput("idle_wt_ready", bus.wt_ready, 1);

    // Eight beats only: start must be ignored until the ninth arrives.
    cur_w0 = 9'h1FF;
    cur_w1 = 9'h000;
    loadWeights(cur_w0, cur_w1, 0, 7);
    cfg_cols = 8'd5;
    cfg_rows = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checkOutput("partial_wt_busy", busy, 0);
    checkOutput("partial_wt_ready", bus.wt_ready, 1);
    loadWeights(cur_w0, cur_w1, 8, 8);

    runFrame("const", 5, 1, -1, 0, 1'b0, last_d);
    checkOutput("const_value", last_d, expOut(9, -9));

    cur_w0 = 9'b101100110;
    cur_w1 = 9'b010011011;
    loadWeights(cur_w0, cur_w1, 0, 8);
    runFrame("two_rows", 5, 2, -1, 0, 1'b1, last_d);
    runFrame("stall", 5, 1, 2, 4, 1'b1, last_d);

    cur_w0 = 9'b000011111;
    cur_w1 = 9'b000011111;
    loadWeights(cur_w0, cur_w1, 0, 8);
    runFrame("min_cols", 3, 1, -1, 0, 1'b0, last_d);
    checkOutput("plus_one_value", last_d, expOut(1, 1));
    step();
    step();
    checkOutput("hold_ovalid", bus.ovalid, 0);
    checkOutput("hold_dout", bus.dout, expOut(1, 1));

    // Abort a frame with outputs in flight, then confirm weights were forgotten.
    cfg_cols = 8'd5;
    cfg_rows = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'b111);
    applyStimulus(1'b0, 3'b000);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_ovalid", bus.ovalid, 1);
    rstn = 1'b0;
    #1;
    checkOutput("abort_dout", bus.dout, 0);
    checkOutput("abort_ovalid", bus.ovalid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_wt_ready", bus.wt_ready, 0);
    step();
    rstn = 1'b1;
    step();
    step();
    checkOutput("post_abort_wt_ready", bus.wt_ready, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'b111);
      checkOutput("noload_busy", busy, 0);
      checkOutput("noload_done", done, 0);
      checkOutput("noload_ovalid", bus.ovalid, 0);
    end
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
